game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game controller for FPGAppy Bird. It sequences a round through idle, play, death-freeze and game-over phases. It gates the physics tick and flap input toward the bird and pipe datapaths and holds those datapaths in reset between rounds. It keeps the running BCD score and the session best score, which feed the seven-segment display path.

## Interface
Parameters:
- HOLD_TICKS, 50, number of physics ticks the world stays frozen after a death (2 s at 25 Hz); legal range 1..255.

Ports:
- i_clk  in  1  system clock; all logic is in this domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_tick  in  1  physics-rate strobe, one i_clk cycle wide.
- i_flap  in  1  flap button level, already synchronized and active-high.
- i_collide  in  1  collision level: pipe hit or out of bounds.
- i_point  in  1  pipe-passed strobe, one i_clk cycle wide.
- o_state  out  2  IDLE=0, PLAY=1, DEAD=2, OVER=3.
- o_world_rst  out  1  reset to the bird and pipe datapaths.
- o_phys_tick  out  1  gated physics strobe to the bird and pipe datapaths.
- o_flap_pulse  out  1  qualified flap strobe to the bird.
- o_score  out  16  current score, 4 packed BCD digits, [15:12] is the MS digit.
- o_best  out  16  best score this session, packed BCD.
- o_new_best  out  1  the last finished round set a new best.

## Operation
- Flap edge: flap_prev is registered every cycle. edge = i_flap & ~flap_prev. flap_prev resets to 1, so a button held through reset produces no edge.
- IDLE:
  - o_world_rst = 1.
  - edge -> PLAY. On this transition o_score clears to 0 and o_new_best clears to 0.
  - The edge that starts the round does not produce o_flap_pulse.
- PLAY:
  - o_world_rst = 0.
  - o_phys_tick = i_tick.
  - edge -> o_flap_pulse.
  - i_point increments o_score in BCD with decimal carry. The score saturates at 9999 and does not wrap.
  - i_collide -> DEAD.
- DEAD:
  - o_world_rst = 0 and o_phys_tick = 0, which freezes the frame.
  - Flap edges are ignored.
  - A hold counter counts i_tick. On the i_tick that makes the count equal HOLD_TICKS -> OVER.
- OVER:
  - World stays frozen, o_world_rst = 0.
  - edge -> IDLE.
- Best update: on the PLAY->DEAD transition, if o_score > o_best (unsigned compare of packed BCD), then o_best <= o_score and o_new_best <= 1.
- Inputs ignored outside PLAY: i_point, and i_collide outside PLAY.
- Simultaneous events in PLAY:
  - collide + point in the same cycle: collision wins and the point is not counted.
  - collide + edge in the same cycle: DEAD, and no o_flap_pulse.
- Best-score compare uses the score value before any same-cycle point. Given the rule above, no point is counted in that cycle anyway.
- Reset (any state, mid-round included):
  - state = IDLE, o_world_rst = 1.
  - o_phys_tick = 0, o_flap_pulse = 0.
  - o_score = 0, o_best = 0, o_new_best = 0.
  - hold counter = 0, flap_prev = 1.
  - Best is lost on reset by design.

## Timing
- State, score, best, new_best, hold counter and o_flap_pulse are registered and change on the i_clk edge after the cause is sampled.
  - Edge sampled in cycle N -> o_flap_pulse high in cycle N+1 only.
  - Edge in IDLE at cycle N -> o_state=PLAY and o_world_rst=0 from N+1.
- o_world_rst and o_state decode directly from the state register; they carry no extra latency.
- o_phys_tick = i_tick & (state==PLAY). It is combinational, has zero latency, and is glitch-free because both terms are registered.
- The hold counter is cleared on entry to DEAD. The first i_tick in DEAD counts as 1.
- A score increment is visible on o_score the cycle after i_point.
- The best-score update is visible the cycle after the PLAY->DEAD transition is sampled, i.e. in the first DEAD cycle.
- A held flap yields exactly one edge. The next edge requires i_flap low for at least one cycle.

## Test plan
- Reset, then i_flap pulse: o_world_rst drops the cycle after the edge, o_state=1, no o_flap_pulse. A second flap gives exactly one o_flap_pulse cycle, one cycle after its edge.
- In PLAY, 12 i_point strobes then i_collide: o_score=0x0012 and o_best=0x0012 in the first DEAD cycle, o_new_best=1. Subsequent i_tick do not appear on o_phys_tick.
- HOLD_TICKS=3: in DEAD, flap edges ignored. The 3rd i_tick moves to OVER. A flap edge moves to IDLE (o_world_rst=1). The next flap edge moves to PLAY with o_score=0 and o_best still 0x0012.
- Second round scoring 5, then collide: o_best stays 0x0012 and o_new_best=0. Score 9998 plus 3 points reads 0x9999, and 0x0099 plus 1 reads 0x0100.
- Same-cycle i_collide+i_point+flap edge in PLAY: DEAD, score unchanged, no o_flap_pulse.
- i_rst asserted mid-PLAY: next cycle o_state=0, o_world_rst=1, o_score=0, o_best=0. A flap held high through reset release does not start a round.

Source files
------------

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Round controller for FPGAppy Bird. Steps a round through IDLE -> PLAY ->
// DEAD (frozen hold) -> OVER -> IDLE. It gates the physics tick and the flap
// strobe toward the bird/pipe datapaths and holds them in reset while idle.
// It also keeps the running BCD score and the session best score.
//
// Parameters:
//   HOLD_TICKS   physics ticks the frame stays frozen after a death (1..255)
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_tick       physics-rate strobe (one cycle)
//   i_flap       synchronized flap button level
//   i_collide    collision level (pipe hit / out of bounds)
//   i_point      pipe-passed strobe (one cycle)
//   o_state      IDLE=0, PLAY=1, DEAD=2, OVER=3
//   o_world_rst  reset to bird and pipe datapaths
//   o_phys_tick  gated physics strobe
//   o_flap_pulse qualified flap strobe to the bird
//   o_score      current score, 4 packed BCD digits
//   o_best       best score this session, packed BCD
//   o_new_best   last finished round set a new best
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int HOLD_TICKS = 50
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tick,
    input  logic        i_flap,
    input  logic        i_collide,
    input  logic        i_point,
    output logic [1:0]  o_state,
    output logic        o_world_rst,
    output logic        o_phys_tick,
    output logic        o_flap_pulse,
    output logic [15:0] o_score,
    output logic [15:0] o_best,
    output logic        o_new_best
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS);

    // Packed-BCD increment with decimal carry; holds at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                carry = 1'b0;
            end
        end
        if (v == 16'h9999) begin
            r = v;
        end else begin
            r = r;
        end
        return r;
    endfunction

    logic [1:0]  state_r,      state_nxt_s;
    logic        flap_prev_r;
    logic [7:0]  hold_cnt_r,   hold_cnt_nxt_s;
    logic [15:0] score_r,      score_nxt_s;
    logic [15:0] best_r,       best_nxt_s;
    logic        new_best_r,   new_best_nxt_s;
    logic        flap_pulse_r, flap_pulse_nxt_s;
    logic        flap_edge_s;

    // Rising edge of the flap level; flap_prev_r resets high so a button
    // held through reset does not count as a press.
    assign flap_edge_s = i_flap & ~flap_prev_r;

    // Next-state, score, best and flap-pulse decisions for the current phase.
    always_comb begin
        state_nxt_s      = state_r;
        hold_cnt_nxt_s   = hold_cnt_r;
        score_nxt_s      = score_r;
        best_nxt_s       = best_r;
        new_best_nxt_s   = new_best_r;
        flap_pulse_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // The starting press does not flap the bird.
                if (flap_edge_s) begin
                    state_nxt_s    = ST_PLAY;
                    score_nxt_s    = 16'h0000;
                    new_best_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // A collision outranks a same-cycle point or flap.
                if (i_collide) begin
                    state_nxt_s    = ST_DEAD;
                    hold_cnt_nxt_s = 8'd0;
                    if (score_r > best_r) begin
                        best_nxt_s     = score_r;
                        new_best_nxt_s = 1'b1;
                    end else begin
                        best_nxt_s = best_r;
                    end
                end else begin
                    flap_pulse_nxt_s = flap_edge_s;
                    if (i_point) begin
                        score_nxt_s = bcd_inc(score_r);
                    end else begin
                        score_nxt_s = score_r;
                    end
                end
            end
            ST_DEAD: begin
                if (i_tick) begin
                    hold_cnt_nxt_s = hold_cnt_r + 8'd1;
                    if ((hold_cnt_r + 8'd1) == HOLD_LAST) begin
                        state_nxt_s = ST_OVER;
                    end else begin
                        state_nxt_s = ST_DEAD;
                    end
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r;
                end
            end
            ST_OVER: begin
                if (flap_edge_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OVER;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            flap_prev_r  <= 1'b1;
            hold_cnt_r   <= 8'd0;
            score_r      <= 16'h0000;
            best_r       <= 16'h0000;
            new_best_r   <= 1'b0;
            flap_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            flap_prev_r  <= i_flap;
            hold_cnt_r   <= hold_cnt_nxt_s;
            score_r      <= score_nxt_s;
            best_r       <= best_nxt_s;
            new_best_r   <= new_best_nxt_s;
            flap_pulse_r <= flap_pulse_nxt_s;
        end
    end

    // Both terms of the tick gate are registered/strobed, so no glitches.
    assign o_phys_tick  = i_tick & (state_r == ST_PLAY);
    assign o_world_rst  = (state_r == ST_IDLE);
    assign o_state      = state_r;
    assign o_flap_pulse = flap_pulse_r;
    assign o_score      = score_r;
    assign o_best       = best_r;
    assign o_new_best   = new_best_r;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        flap;
    logic        collide;
    logic        point;
    logic [1:0]  state;
    logic        world_rst;
    logic        phys_tick;
    logic        flap_pulse;
    logic [15:0] score;
    logic [15:0] best;
    logic        new_best;

    int checks_total;
    int checks_passed;

    game_sequencer #(.HOLD_TICKS(3)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tick       (tick),
        .i_flap       (flap),
        .i_collide    (collide),
        .i_point      (point),
        .o_state      (state),
        .o_world_rst  (world_rst),
        .o_phys_tick  (phys_tick),
        .o_flap_pulse (flap_pulse),
        .o_score      (score),
        .o_best       (best),
        .o_new_best   (new_best)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; registered outputs are settled afterwards.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic points(input int n);
        point = 1'b1;
        repeat (n) cycle();
        point = 1'b0;
    endtask

    // From DEAD: three ticks to OVER, press to IDLE, press to PLAY.
    task automatic next_round();
        flap = 1'b0; cycle();
        tick = 1'b1; repeat (3) cycle(); tick = 1'b0;
        flap = 1'b1; cycle(); flap = 1'b0; cycle();
        flap = 1'b1; cycle(); flap = 1'b0; cycle();
    endtask

    initial begin
        checks_total = 0; checks_passed = 0;
        rst = 1'b1; tick = 1'b0; flap = 1'b0; collide = 1'b0; point = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        check("rst_state", {14'd0, state}, 16'd0);
        check("rst_world_rst", {15'd0, world_rst}, 16'd1);
        check("rst_score", score, 16'h0000);
        check("rst_best", best, 16'h0000);
        check("rst_new_best", {15'd0, new_best}, 16'd0);
        check("rst_flap_pulse", {15'd0, flap_pulse}, 16'd0);
        cycle();

        // Start press
        flap = 1'b1; cycle();
        check("start_state", {14'd0, state}, 16'd1);
        check("start_world_rst", {15'd0, world_rst}, 16'd0);
        check("start_no_pulse", {15'd0, flap_pulse}, 16'd0);
        flap = 1'b0; cycle();
        check("idle_gap_no_pulse", {15'd0, flap_pulse}, 16'd0);
        flap = 1'b1; cycle();
        check("flap_pulse", {15'd0, flap_pulse}, 16'd1);
        cycle();
        check("flap_held_one_pulse", {15'd0, flap_pulse}, 16'd0);
        flap = 1'b0; cycle();
        tick = 1'b1; #1;
        check("play_phys_tick", {15'd0, phys_tick}, 16'd1);
        cycle(); tick = 1'b0;

        // Twelve points then death
        points(12);
        check("score_12", score, 16'h0012);
        collide = 1'b1; cycle(); collide = 1'b0;
        check("dead_state", {14'd0, state}, 16'd2);
        check("dead_score", score, 16'h0012);
        check("dead_best", best, 16'h0012);
        check("dead_new_best", {15'd0, new_best}, 16'd1);
        tick = 1'b1; #1;
        check("dead_phys_tick", {15'd0, phys_tick}, 16'd0);
        cycle(); tick = 1'b0;
        flap = 1'b1; cycle();
        check("dead_flap_ignored_state", {14'd0, state}, 16'd2);
        check("dead_flap_no_pulse", {15'd0, flap_pulse}, 16'd0);
        flap = 1'b0; cycle();
        tick = 1'b1; cycle(); tick = 1'b0;
        check("hold_2_ticks", {14'd0, state}, 16'd2);
        tick = 1'b1; cycle(); tick = 1'b0;
        check("hold_3_ticks_over", {14'd0, state}, 16'd3);
        flap = 1'b1; cycle();
        check("over_to_idle", {14'd0, state}, 16'd0);
        check("over_world_rst", {15'd0, world_rst}, 16'd1);
        flap = 1'b0; cycle();
        flap = 1'b1; cycle();
        check("round2_state", {14'd0, state}, 16'd1);
        check("round2_score", score, 16'h0000);
        check("round2_best", best, 16'h0012);
        check("round2_new_best_clr", {15'd0, new_best}, 16'd0);
        flap = 1'b0; cycle();

        // Lower score keeps best
        points(5);
        collide = 1'b1; cycle(); collide = 1'b0;
        check("r2_score", score, 16'h0005);
        check("r2_best_kept", best, 16'h0012);
        check("r2_no_new_best", {15'd0, new_best}, 16'd0);

        // BCD carry and saturation
        next_round();
        points(99);
        check("score_0099", score, 16'h0099);
        points(1);
        check("score_0100", score, 16'h0100);
        points(9898);
        check("score_9998", score, 16'h9998);
        points(3);
        check("score_sat_9999", score, 16'h9999);
        collide = 1'b1; cycle(); collide = 1'b0;
        check("best_9999", best, 16'h9999);

        // Collide + point + flap edge together
        next_round();
        points(2);
        collide = 1'b1; point = 1'b1; flap = 1'b1; cycle();
        collide = 1'b0; point = 1'b0;
        check("simul_state", {14'd0, state}, 16'd2);
        check("simul_score", score, 16'h0002);
        check("simul_no_pulse", {15'd0, flap_pulse}, 16'd0);
        cycle();
        check("simul_no_pulse_later", {15'd0, flap_pulse}, 16'd0);

        // Reset mid-round with flap held through release
        next_round();
        points(1);
        rst = 1'b1; flap = 1'b1; cycle();
        check("mid_rst_state", {14'd0, state}, 16'd0);
        check("mid_rst_world_rst", {15'd0, world_rst}, 16'd1);
        check("mid_rst_score", score, 16'h0000);
        check("mid_rst_best", best, 16'h0000);
        rst = 1'b0; cycle(); cycle();
        check("held_flap_no_start", {14'd0, state}, 16'd0);
        flap = 1'b0; cycle();
        flap = 1'b1; cycle();
        check("fresh_press_starts", {14'd0, state}, 16'd1);
        flap = 1'b0; cycle();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
